serial_sub: RTL and testbench
=============================

// Module: serial_sub
// PURPOSE
//   Bit-serial N-bit subtractor: diff = a - b, LSB first, one bit per clock.
//   Built around a 1-bit full-subtractor cell.
//   Sits beside the combinational adder datapath as its subtract/compare unit.
//   Valid/ready handshakes on both operand and result sides.
// PARAMETERS
//   WIDTH   8   operand/result width in bits (>=2)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operands a,b valid
//   in_ready   out  1      block can accept operands (high only in IDLE)
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   out_valid  out  1      result valid (high only in DONE)
//   out_ready  in   1      consumer accepts result
//   diff       out  WIDTH  (a - b) mod 2^WIDTH
//   borrow     out  1      1 when a < b, unsigned
//   ovf        out  1      signed overflow; present only with SERIAL_SUB_OVF_EN
// BEHAVIOUR
//   - Reset (async assert, rst_n=0): state=IDLE; out_valid=0; diff=0; borrow=0; ovf=0;
//     bit counter=0; in_ready=1 once the block is out of reset.
//   - FSM: IDLE -> RUN on in_valid&&in_ready; RUN -> DONE after WIDTH bit cycles;
//     DONE -> IDLE on out_valid&&out_ready.
//   - Accept edge T: a, b latched into shift registers; borrow-in cleared to 0.
//   - RUN: on edges T+1..T+WIDTH, bit i uses the cell: d = a_i^b_i^bin;
//     bout = (~a_i&b_i) | (~(a_i^b_i)&bin).
//     d shifts into diff from the MSB end; bin <= bout.
//   - After edge T+WIDTH: out_valid=1; borrow = final bout.
//     Latency from accept to out_valid is exactly WIDTH cycles.
//   - DONE: diff, borrow and ovf are held stable while out_ready=0, with no limit.
//   - in_ready is combinational (state==IDLE).
//     No accept in DONE, even in the cycle where out_ready is high.
//   - a, b and in_valid are ignored outside IDLE; the operand registers do not change.
//   - out_ready is ignored outside DONE.
//   - Outputs are registered. diff/borrow keep their last result in IDLE;
//     they are meaningful only while out_valid=1.
//   - Reset asserted mid-RUN or in DONE: the operation is discarded and all
//     reset values apply immediately.
//   - Boundaries:
//     - a==b gives diff=0, borrow=0.
//     - 0 - (2^WIDTH-1) gives diff=1, borrow=1 (wrap-around).
//     - The bit counter wraps at WIDTH-1 to 0.
// CONFIGURATION
//   SERIAL_SUB_OVF_EN defined:
//     - ovf port exists. ovf = (a[W-1]!=b[W-1]) && (diff[W-1]!=a[W-1]).
//     - It is registered with diff and valid under the same out_valid.
//     - Reset value is 0.
//   SERIAL_SUB_OVF_EN undefined:
//     - No ovf port and no sign-tracking register.
//     - All other behaviour is identical.
// STRUCTURE
//   Package serial_sub_pkg:
//     - FSM state typedef {IDLE, RUN, DONE}, 2-bit encoding.
//     - Counter-width function clog2(WIDTH).
//   Sub-module sub1 (1-bit full subtractor):
//     - Ports a, b, bin, d, bout; purely combinational.
//     - One instance in the serial datapath.
//   Top: FSM, bit counter, operand and result shift registers, borrow flop.
// TESTING (WIDTH=8)
//   1. a=0x05, b=0x03, accepted at edge T -> out_valid rises after T+8; diff=0x02, borrow=0.
//   2. a=0x03, b=0x05 -> diff=0xFE, borrow=1.
//      a=0x00, b=0xFF -> diff=0x01, borrow=1.
//   3. a=0xFF, b=0xFF -> diff=0x00, borrow=0.
//      Back-to-back ops with out_ready=1 -> accepts spaced WIDTH+2 cycles apart.
//   4. out_ready=0 for 5 cycles in DONE -> out_valid, diff and borrow hold;
//      in_ready=0; in_valid pulses are ignored.
//   5. rst_n=0 at RUN bit 4 -> out_valid=0 and diff=0 at once;
//      after release in_ready=1 and the next op (0x10-0x01 -> 0x0F) is correct.
//   6. With SERIAL_SUB_OVF_EN:
//      - a=0x80, b=0x01 -> diff=0x7F, ovf=1, borrow=0.
//      - a=0x7F, b=0xFF -> diff=0x80, ovf=1, borrow=1.
//      - 0x05-0x03 -> ovf=0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_sub_sub1.sv
// 1-bit full-subtractor cell: d = a - b - bin, with borrow out.
module serial_sub_sub1 (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor, LSB first, valid/ready on both sides.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic            bin;
  logic            cell_d, cell_bout;
  logic            last_bit;
  logic            accept;
  logic            release_res;

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign accept      = in_valid && in_ready;
  assign release_res = out_valid && out_ready;
  assign last_bit    = (cnt == CW'(WIDTH - 1));

  serial_sub_sub1 u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (bin),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    if (release_res) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shift registers, borrow chain and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      bin    <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else if (accept) begin
      cnt  <= '0;
      a_sr <= a;
      b_sr <= b;
      bin  <= 1'b0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      bin  <= cell_bout;
      diff <= {cell_d, diff[WIDTH-1:1]};
      cnt  <= last_bit ? '0 : cnt + CW'(1);
      if (last_bit) borrow <= cell_bout;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Operand signs are captured at accept because the shift registers lose them
  logic a_msb, b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (state == RUN && last_bit) begin
      ovf <= (a_msb != b_msb) && (cell_d != a_msb);
    end
  end
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Directed, table-driven bench for serial_sub (WIDTH=8).
module tb_serial_sub;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  serial_sub #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] ia, input logic [7:0] ib);
    int w;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    a = ia;
    b = ib;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'h00;
    b = 8'h00;
  endtask

  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                        output logic [7:0] gd, output logic gb, output int lat);
    start_op(ia, ib);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    gd = diff;
    gb = borrow;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] gd;
    logic       gb;
    int         lat;
    int         acc0, acc1, w;
    logic [7:0] bb_diff;
`ifdef SERIAL_SUB_OVF_EN
    logic [8:0] ov_col;
    ov_col = 9'b011110000;
`endif

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    vecs[2] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 8'h7F, 1'b0};
    vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1};
    vecs[6] = '{8'hC8, 8'h64, 8'h64, 1'b0};
    vecs[7] = '{8'h64, 8'hC8, 8'h9C, 1'b1};
    vecs[8] = '{8'h3C, 8'h0F, 8'h2D, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, gd, gb, lat);
      check($sformatf("v%0d_diff", i), gd, vecs[i].d);
      check($sformatf("v%0d_borrow", i), gb, vecs[i].bo);
      check($sformatf("v%0d_latency", i), lat, 8);
`ifdef SERIAL_SUB_OVF_EN
      check($sformatf("v%0d_ovf", i), ovf, ov_col[i]);
`endif
    end

    // Back-to-back with out_ready held high: accepts every WIDTH+2 cycles
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a         = 8'h09;
    b         = 8'h04;
    acc0 = -1;
    acc1 = -1;
    bb_diff = 8'h00;
    for (int c = 0; c < 30; c++) begin
      if (in_ready) begin
        if (acc0 < 0) acc0 = c;
        else if (acc1 < 0) acc1 = c;
      end
      if (out_valid && bb_diff == 8'h00) bb_diff = diff;
      @(negedge clk);
    end
    in_valid = 1'b0;
    w = 0;
    while (!in_ready && w < 30) begin
      @(negedge clk);
      w++;
    end
    out_ready = 1'b0;
    check("b2b_spacing", acc1 - acc0, 10);
    check("b2b_diff", bb_diff, 8'h05);

    // Result held in DONE while out_ready is low; operands ignored
    start_op(8'h03, 8'h05);
    w = 0;
    while (!out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      a = 8'hFF;
      b = 8'h00;
      check("hold_out_valid", out_valid, 1);
      check("hold_diff", diff, 8'hFE);
      check("hold_borrow", borrow, 1);
      check("hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hold_release_in_ready", in_ready, 1);
    check("hold_release_out_valid", out_valid, 0);

    // Reset in the middle of RUN discards the operation
    start_op(8'hAA, 8'h11);
    repeat (4) @(negedge clk);
    check("mid_run_diff_nonzero", (diff != 8'h00), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_diff", diff, 0);
    check("midrst_borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("midrst_ovf", ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    run_op(8'h10, 8'h01, gd, gb, lat);
    check("post_rst_diff", gd, 8'h0F);
    check("post_rst_borrow", gb, 0);
    check("post_rst_latency", lat, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
